// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: 1:4 valid/ready stream demultiplexer.
// Each input beat is routed by in_sel into one of four one-entry output slots.
// Every slot is an independent registered buffer, so a stalled consumer blocks
// only beats addressed to its own channel.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready is combinational)
//   in_data, in_sel          input payload and destination channel 0..3
//   out_valid[3:0]           per-channel slot-full flags
//   out_ready[3:0]           per-channel consumer ready
//   out_data0..3             per-channel slot payloads
//   cnt0..3                  per-channel delivered-beat counters (wrapping)
//   err                      sticky input-protocol violation flag
module demux_1_4_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic             err
);

  localparam int unsigned NCH = 4;

  logic [NCH-1:0]   full_q, full_d;
  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] data_d [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];

  // Snapshot of the previous cycle's input, used only for protocol checking
  logic             stall_q, stall_d;
  logic [1:0]       prev_sel_q, prev_sel_d;
  logic [WIDTH-1:0] prev_data_q, prev_data_d;
  logic             err_q, err_d;

  logic             accept;
  logic [NCH-1:0]   deliver;

  // Ready when the addressed slot is empty or draining this cycle
  always_comb begin
    in_ready = ~full_q[in_sel] | out_ready[in_sel];
  end

  assign accept  = in_valid & in_ready;
  assign deliver = full_q & out_ready;

  // Slot next-state: a load wins over a drain, so load+drain keeps the slot full
  always_comb begin
    full_d = full_q;
    for (int i = 0; i < NCH; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];
      if (accept && (in_sel == 2'(i))) begin
        full_d[i] = 1'b1;
        data_d[i] = in_data;
      end else if (deliver[i]) begin
        full_d[i] = 1'b0;
      end
      if (deliver[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A stalled beat must reappear unchanged in the following cycle
  always_comb begin
    stall_d     = in_valid & ~in_ready;
    prev_sel_d  = in_sel;
    prev_data_d = in_data;
    err_d       = err_q;
    if (stall_q && (!in_valid || (in_sel != prev_sel_q) || (in_data != prev_data_q))) begin
      err_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      stall_q     <= 1'b0;
      prev_sel_q  <= '0;
      prev_data_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      full_q      <= full_d;
      stall_q     <= stall_d;
      prev_sel_q  <= prev_sel_d;
      prev_data_q <= prev_data_d;
      err_q       <= err_d;
      for (int i = 0; i < NCH; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign out_valid = full_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];
  assign err       = err_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: directed self-checking bench for demux_1_4_stream.
module tb_demux_1_4_stream;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
  logic             err;

  int n_chk;
  int n_bad;

  demux_1_4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  function automatic logic [WIDTH-1:0] od(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    out_ready = 4'b0000;
    drive(1'b0, 2'd0, 4'h0);

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data0", 32'(out_data0), 32'h0);
    chk("rst_cnt0", 32'(cnt0), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;

    // Routing and latency: A,B,C,D to channels 0..3
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 4'(4'hA + k));
      #1;
      chk($sformatf("route_rdy%0d", k), 32'(in_ready), 32'h1);
      cyc();
      chk($sformatf("route_vld%0d", k), 32'(out_valid), 32'(4'b0001 << k));
      chk($sformatf("route_dat%0d", k), 32'(od(k)), 32'(4'hA + k));
    end
    drive(1'b0, 2'd0, 4'h0);
    cyc();
    chk("route_empty", 32'(out_valid), 32'h0);
    chk("route_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h01010101);
    chk("route_hold0", 32'(out_data0), 32'hA);

    // Backpressure isolation on channel 0
    out_ready = 4'b1110;
    drive(1'b1, 2'd0, 4'h5);
    #1;
    chk("bp_rdy5", 32'(in_ready), 32'h1);
    cyc();
    drive(1'b1, 2'd0, 4'h6);
    #1;
    chk("bp_rdy6_stall", 32'(in_ready), 32'h0);
    cyc();
    chk("bp_stable_dat", 32'(out_data0), 32'h5);
    chk("bp_stable_vld", 32'(out_valid), 32'h1);
    out_ready = 4'b1111;
    #1;
    chk("bp_rdy6_go", 32'(in_ready), 32'h1);
    cyc();
    chk("bp_dat6", 32'(out_data0), 32'h6);
    chk("bp_cnt0", 32'(cnt0), 32'h2);
    // Channel 0 blocked with beat 6; a channel-2 beat must still pass
    out_ready = 4'b1110;
    drive(1'b0, 2'd0, 4'h0);
    #1;
    chk("bp_rdy_sel0_blk", 32'(in_ready), 32'h0);
    drive(1'b1, 2'd2, 4'h7);
    #1;
    chk("bp_rdy7", 32'(in_ready), 32'h1);
    cyc();
    chk("bp_vld_0_2", 32'(out_valid), 32'h5);
    chk("bp_dat7", 32'(out_data2), 32'h7);
    drive(1'b0, 2'd0, 4'h0);
    cyc();
    chk("bp_vld_after2", 32'(out_valid), 32'h1);
    chk("bp_cnt2", 32'(cnt2), 32'h2);
    out_ready = 4'b1111;
    cyc();
    chk("bp_cnt0_final", 32'(cnt0), 32'h3);
    chk("bp_err", 32'(err), 32'h0);

    // Full throughput on channel 1 (cnt1 starts at 1)
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 2'd1, 4'(k));
      #1;
      chk($sformatf("tp_rdy%0d", k), 32'(in_ready), 32'h1);
      cyc();
      chk($sformatf("tp_dat%0d", k), 32'(out_data1), 32'(k));
    end
    drive(1'b0, 2'd0, 4'h0);
    cyc();
    chk("tp_cnt1", 32'(cnt1), 32'd17);

    // Reset mid-cycle with all slots full
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 4'(8 + k));
      cyc();
    end
    drive(1'b0, 2'd0, 4'h0);
    chk("mr_full", 32'(out_valid), 32'hF);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_data", {16'h0, out_data3, out_data2, out_data1, out_data0}, 32'h0);
    chk("mr_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
    chk("mr_err", 32'(err), 32'h0);
    cyc();
    chk("mr_hold_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // Counter wrap on channel 3: 256 deliveries
    out_ready = 4'b1000;
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 2'd3, 4'(k));
      cyc();
    end
    drive(1'b0, 2'd0, 4'h0);
    chk("wrap_cnt255", 32'(cnt3), 32'd255);
    cyc();
    chk("wrap_cnt3", 32'(cnt3), 32'd0);
    chk("wrap_others", {8'h0, cnt2, cnt1, cnt0}, 32'h0);

    // Protocol error: stalled beat changes its data
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 4'h3);
    cyc();
    #1;
    chk("pe_stall_rdy", 32'(in_ready), 32'h0);
    cyc();
    chk("pe_no_err_yet", 32'(err), 32'h0);
    in_data = 4'h4;
    cyc();
    chk("pe_err_set", 32'(err), 32'h1);
    drive(1'b0, 2'd0, 4'h0);
    out_ready = 4'b1111;
    cyc();
    cyc();
    chk("pe_err_sticky", 32'(err), 32'h1);
    rst = 1'b1;
    #1;
    chk("pe_err_clr", 32'(err), 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
